// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/scoreboard bus between the execute/memory stages, the issue stage
// and the register-file write port.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 64
);
   logic              issue_valid;
   logic [4:0]        issue_rd;
   logic              issue_ready;
   logic [4:0]        rs1_sel;
   logic [4:0]        rs2_sel;
   logic              rs1_busy;
   logic              rs2_busy;
   logic              src0_valid;
   logic [4:0]        src0_rd;
   logic [DATA_W-1:0] src0_data;
   logic              src0_ready;
   logic              src1_valid;
   logic [4:0]        src1_rd;
   logic [DATA_W-1:0] src1_data;
   logic              src1_ready;
   logic              write_en;
   logic [4:0]        write_sel;
   logic [DATA_W-1:0] write_data;

   modport master (
      output issue_valid, issue_rd, rs1_sel, rs2_sel,
      output src0_valid, src0_rd, src0_data,
      output src1_valid, src1_rd, src1_data,
      input  issue_ready, rs1_busy, rs2_busy, src0_ready, src1_ready,
      input  write_en, write_sel, write_data
   );

   modport slave (
      input  issue_valid, issue_rd, rs1_sel, rs2_sel,
      input  src0_valid, src0_rd, src0_data,
      input  src1_valid, src1_rd, src1_data,
      output issue_ready, rs1_busy, rs2_busy, src0_ready, src1_ready,
      output write_en, write_sel, write_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and
// LSU, plus a per-register pending-write scoreboard for RAW hazard detection.
module regfile_wb_arbiter #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_wb_arbiter_if.slave  bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic             SRC0    = 1'b0;
   localparam logic             SRC1    = 1'b1;

   logic              r_last;
   logic [CNT_W-1:0]  r_cnt [32];
   logic              r_write_en;
   logic [4:0]        r_write_sel;
   logic [DATA_W-1:0] r_write_data;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_gnt_any;
   logic [4:0]        w_gnt_rd;
   logic [DATA_W-1:0] w_gnt_data;
   logic [31:0]       w_inc;
   logic [31:0]       w_dec;
   logic              w_issue_ready;

   // On a tie the source that did not win last time gets the port.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (bus.src0_valid && bus.src1_valid) begin
         w_gnt0 = (r_last == SRC1);
         w_gnt1 = (r_last == SRC0);
      end else begin
         w_gnt0 = bus.src0_valid;
         w_gnt1 = bus.src1_valid;
      end
      w_gnt_any  = w_gnt0 | w_gnt1;
      w_gnt_rd   = w_gnt1 ? bus.src1_rd   : bus.src0_rd;
      w_gnt_data = w_gnt1 ? bus.src1_data : bus.src0_data;
   end

   // x0 never sets an inc/dec bit, so its counter stays at zero forever.
   always_comb begin
      w_inc = '0;
      w_dec = '0;
      if (w_gnt_any && (w_gnt_rd != 5'd0)) begin
         w_dec[w_gnt_rd] = 1'b1;
      end
      w_issue_ready = !((bus.issue_rd != 5'd0) &&
                        (r_cnt[bus.issue_rd] == CNT_MAX) &&
                        !w_dec[bus.issue_rd]);
      if (bus.issue_valid && w_issue_ready && (bus.issue_rd != 5'd0)) begin
         w_inc[bus.issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 32; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 32; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
               r_cnt[i] <= r_cnt[i] - CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last       <= SRC1;
         r_write_en   <= 1'b0;
         r_write_sel  <= '0;
         r_write_data <= '0;
      end else begin
         r_write_en <= w_gnt_any && (w_gnt_rd != 5'd0);
         if (w_gnt_any) begin
            r_last       <= w_gnt1 ? SRC1 : SRC0;
            r_write_sel  <= w_gnt_rd;
            r_write_data <= w_gnt_data;
         end
      end
   end

   assign bus.issue_ready = w_issue_ready;
   assign bus.rs1_busy    = (bus.rs1_sel != 5'd0) && (r_cnt[bus.rs1_sel] != '0);
   assign bus.rs2_busy    = (bus.rs2_sel != 5'd0) && (r_cnt[bus.rs2_sel] != '0);
   assign bus.src0_ready  = w_gnt0;
   assign bus.src1_ready  = w_gnt1;
   assign bus.write_en    = r_write_en;
   assign bus.write_sel   = r_write_sel;
   assign bus.write_data  = r_write_data;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: src0 (ALU) and src1 (load/store unit).
- Keeps a per-register pending-write scoreboard so the issue stage can detect RAW hazards on rs1/rs2.
- Sits between the execute/memory stages and the register file write port (write_en / write_sel / data).

Parameters:
- DATA_W, 64, writeback data width.
- CNT_W, 2, width of each per-register pending-write counter. Saturation value is 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- issue_valid  input  1  an instruction with a destination register is issuing.
- issue_rd  input  5  destination register of the issuing instruction.
- issue_ready  output  1  scoreboard can accept the issue.
- rs1_sel  input  5  hazard query register 1.
- rs2_sel  input  5  hazard query register 2.
- rs1_busy  output  1  rs1 has a pending write.
- rs2_busy  output  1  rs2 has a pending write.
- src0_valid  input  1  ALU writeback request.
- src0_rd  input  5  ALU destination register.
- src0_data  input  DATA_W  ALU result.
- src0_ready  output  1  ALU request granted this cycle.
- src1_valid  input  1  LSU writeback request.
- src1_rd  input  5  LSU destination register.
- src1_data  input  DATA_W  load result.
- src1_ready  output  1  LSU request granted this cycle.
- write_en  output  1  register file write enable.
- write_sel  output  5  register file write address.
- write_data  output  DATA_W  register file write data.

Behaviour:
- Reset (async, rst_n low):
  - All counters are 0.
  - write_en=0, write_sel=0, write_data=0.
  - Last-grant pointer = src1, so src0 wins the first tie.
  - Outputs stay at these values while rst_n is low. Reset mid-operation drops all pending and buffered writes.
- Handshake: a transfer occurs when srcN_valid && srcN_ready. Sources hold valid, rd and data stable until they are granted.
- Arbitration (combinational ready):
  - Only src0 valid: grant src0.
  - Only src1 valid: grant src1.
  - Both valid: grant the source not granted last. The pointer updates only on a grant.
  - At most one ready is high per cycle. The ready outputs do not depend on scoreboard state.
- Write port:
  - Registered; 1-cycle latency. A grant in cycle N produces write_en=1, write_sel=rd and write_data=data in cycle N+1.
  - With no grant in cycle N, write_en=0 in N+1 and write_sel/write_data hold their previous values.
  - A granted rd=0 is accepted (ready high) but produces write_en=0.
- Scoreboard: one CNT_W counter per register x1..x31. x0 has no counter and is never busy.
  - Increment: issue_valid && issue_ready && issue_rd!=0.
  - Decrement: a grant with rd!=0, applied at the same clock edge as the grant.
  - Increment and decrement on the same register in the same cycle: count unchanged.
  - issue_ready = 0 only when issue_rd!=0 and its counter is saturated and no decrement of that register occurs this cycle. Otherwise 1.
  - A decrement at count 0 is a protocol error; the counter stays at 0 (no wrap).
  - rsX_busy = (rsX_sel!=0) && (count[rsX_sel]!=0). It reflects registered counter state only, with no same-cycle bypass.
  - A register is therefore busy through the cycle of its grant. It is not busy from the cycle in which write_en is asserted.
- Issue to rd=0: issue_ready=1 and no counter change.

Test Plan:
- Reset: assert rst_n=0 mid-traffic → write_en=0, write_sel=0, write_data=0 and all busy flags 0 immediately. First tie after release grants src0.
- Single write: issue rd=5, then src0 valid rd=5 data=0x1234 → src0_ready same cycle; next cycle write_en=1, write_sel=5, write_data=0x1234; rs1_sel=5 busy 1 before the grant edge, 0 after.
- Contention: src0 and src1 both valid for 4 cycles with distinct rd → grants alternate src0, src1, src0, src1; write port shows one write per cycle in the same order.
- Saturation/WAW: issue rd=7 three times → count 3, fourth issue_ready=0. Issue rd=7 again in the same cycle src1 is granted rd=7 → issue_ready=1 and count stays 3.
- x0: issue rd=0 and src1 valid rd=0 data=0xFFFF → issue_ready=1, src1_ready=1, write_en=0 next cycle, rs2_sel=0 busy 0.
- Back-to-back: src0 valid continuously for 3 cycles with rd 1, 2, 3 and src1 idle → ready every cycle, write_en high for 3 consecutive cycles with write_sel 1, 2, 3.
